// File: rtl/branch_predictor_pkg.sv
// Shared fetch-path definitions: address bus width, reset PC and the
// 2-bit branch-direction counter encodings used by the predictor.
package branch_predictor_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        CNT_SN = 2'b00,
        CNT_WN = 2'b01,
        CNT_WT = 2'b10,
        CNT_ST = 2'b11
    } cnt_e;

endpackage

// File: rtl/bp_counter2.sv
// Next-state function of a 2-bit saturating direction counter; unconditional
// jumps pin the counter to strongly-taken.
module bp_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    input  logic       uncond_i,
    output logic [1:0] cnt_o
);

    // Saturating increment/decrement with the unconditional override first.
    always_comb begin
        cnt_o = cnt_i;
        if (uncond_i) begin
            cnt_o = CNT_ST;
        end else if (taken_i) begin
            if (cnt_i != CNT_ST) begin
                cnt_o = cnt_i + 2'd1;
            end else begin
                cnt_o = cnt_i;
            end
        end else begin
            if (cnt_i != CNT_SN) begin
                cnt_o = cnt_i - 2'd1;
            end else begin
                cnt_o = cnt_i;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational next-PC prediction
// from the fetch PC and single-entry update from resolved branches.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [INST_ADDR_BUS-1:0] pc_i,
    output logic [INST_ADDR_BUS-1:0] next_pc_o,
    output logic                     next_branch_o,
    input  logic                     upd_valid_i,
    input  logic [INST_ADDR_BUS-1:0] upd_pc_i,
    input  logic                     upd_taken_i,
    input  logic [INST_ADDR_BUS-1:0] upd_target_i,
    input  logic                     upd_uncond_i
);

    localparam int IDX_W  = $clog2(BTB_ENTRIES);
    localparam int WORD_W = INST_ADDR_BUS - 2;
    localparam int TAG_W  = WORD_W - IDX_W;

    logic [BTB_ENTRIES-1:0]   valid_r;
    logic [TAG_W-1:0]         tag_r    [BTB_ENTRIES];
    logic [INST_ADDR_BUS-1:0] target_r [BTB_ENTRIES];
    logic [1:0]               cnt_r    [BTB_ENTRIES];

    // Byte-offset bits never take part in indexing or tagging.
    logic [WORD_W-1:0] look_word_s;
    logic [WORD_W-1:0] upd_word_s;
    logic [IDX_W-1:0]  look_idx_s;
    logic [TAG_W-1:0]  look_tag_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic [TAG_W-1:0]  upd_tag_s;
    logic              look_hit_s;
    logic              upd_hit_s;
    logic [1:0]        upd_cnt_s;

    assign look_word_s = WORD_W'(pc_i >> 2);
    assign upd_word_s  = WORD_W'(upd_pc_i >> 2);
    assign look_idx_s  = look_word_s[IDX_W-1:0];
    assign look_tag_s  = look_word_s[WORD_W-1:IDX_W];
    assign upd_idx_s   = upd_word_s[IDX_W-1:0];
    assign upd_tag_s   = upd_word_s[WORD_W-1:IDX_W];
    assign upd_hit_s   = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

    bp_counter2 u_counter (
        .cnt_i    (cnt_r[upd_idx_s]),
        .taken_i  (upd_taken_i),
        .uncond_i (upd_uncond_i),
        .cnt_o    (upd_cnt_s)
    );

    // Lookup reads stored state only, so a same-cycle update is not bypassed.
    always_comb begin
        look_hit_s    = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
        next_branch_o = 1'b0;
        next_pc_o     = pc_i + 32'd4;
        if (look_hit_s && cnt_r[look_idx_s][1]) begin
            next_branch_o = 1'b1;
            next_pc_o     = target_r[look_idx_s];
        end else begin
            next_branch_o = 1'b0;
            next_pc_o     = pc_i + 32'd4;
        end
    end

    // Table update: train on hit, allocate on taken miss, ignore not-taken miss.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                cnt_r[i]    <= CNT_WN;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
            end
        end else if (upd_valid_i) begin
            if (upd_hit_s) begin
                cnt_r[upd_idx_s] <= upd_cnt_s;
                if (upd_taken_i) begin
                    target_r[upd_idx_s] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= upd_target_i;
                cnt_r[upd_idx_s]    <= upd_uncond_i ? CNT_ST : CNT_WT;
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, meaning direct-mapped BTB depth; it is a power of two, minimum 4.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port pc_i, input, InstAddrBus (32), the current fetch PC from the fetch unit.
REQ-005 SHALL have port next_pc_o, output, 32, the predicted next fetch PC.
REQ-006 SHALL have port next_branch_o, output, 1, high when the prediction is taken.
REQ-007 SHALL have port upd_valid_i, input, 1, a resolved control-transfer update from execute.
REQ-008 SHALL have port upd_pc_i, input, 32, the PC of the resolved instruction.
REQ-009 SHALL have port upd_taken_i, input, 1, the actual direction.
REQ-010 SHALL have port upd_target_i, input, 32, the actual taken target.
REQ-011 SHALL have port upd_uncond_i, input, 1, high for JAL/JALR and low for conditional branches.

Function
REQ-012 SHALL index the BTB with pc[IDX+1:2] (IDX = log2(BTB_ENTRIES)) and tag with pc[31:IDX+2].
REQ-013 SHALL hold per entry: valid, tag, 32-bit target and 2-bit saturating counter (00 SN, 01 WN, 10 WT, 11 ST).
REQ-014 SHALL compute the prediction combinationally from pc_i: hit = valid and tag match.
REQ-015 SHALL drive next_branch_o = hit and counter[1]; next_pc_o = target when taken, else pc_i+4 (mod 2^32, wrap from 0xFFFFFFFC to 0x0).
REQ-016 SHALL perform updates on the rising clock edge when upd_valid_i=1; the new contents are visible to lookups from the next cycle.
REQ-017 On update hit: counter increments (saturating at 11) if taken, decrements (saturating at 00) if not taken; the target is overwritten with upd_target_i when taken.
REQ-018 On update miss with upd_taken_i=1: allocate the entry (replacing any occupant) with valid=1, the new tag, the target, and counter=11 if upd_uncond_i else 10.
REQ-019 On update miss with upd_taken_i=0: make no change.
REQ-020 On update hit with upd_uncond_i=1: force the counter to 11.
REQ-021 On a simultaneous lookup and update to the same index: the lookup SHALL return pre-update contents (no bypass).
REQ-022 SHALL ignore upd_pc_i[1:0] and pc_i[1:0] for indexing and tagging.

Reset
REQ-023 While rst_i=1: all valid bits SHALL be 0 and all counters 01; tags and targets need not be reset.
REQ-024 During and right after reset, next_branch_o SHALL be 0 and next_pc_o = pc_i+4.
REQ-025 An update presented in the cycle rst_i deasserts SHALL be applied normally; an update coincident with an asserted reset SHALL be discarded.

Structure
REQ-026 SHALL take the InstAddrBus width, reset PC and counter encodings (SN/WN/WT/ST) from the shared defines file.
REQ-027 Combinational lookup and sequential update SHALL live in this module; one sub-module, bp_counter2 (2-bit saturating update function), is permitted.
REQ-028 Storage SHALL be flops (no SRAM macro), so reset of valid bits is single-cycle.

Verification
REQ-029 Reset, then pc_i=0x00000100 -> next_branch_o=0, next_pc_o=0x00000104.
REQ-030 Update pc=0x100, taken, target=0x200, cond; next cycle pc_i=0x100 -> next_branch_o=1, next_pc_o=0x200.
REQ-031 From REQ-030 state, two not-taken updates at 0x100 -> counter 10->01->00, prediction 0x104 not taken; one taken update -> 01, still not taken.
REQ-032 Aliasing: allocate 0x100 (target 0x200), then taken update 0x140 (same index with 16 entries, target 0x300) -> pc_i=0x100 misses (0x104), pc_i=0x140 predicts 0x300.
REQ-033 Same-cycle lookup/update at 0x100 on an empty BTB -> this cycle not taken, next cycle taken; pc_i=0xFFFFFFFC miss -> next_pc_o=0x00000000.
REQ-034 Assert rst_i asynchronously mid-run after allocations -> all lookups miss immediately; JAL update (uncond, target 0x80) at 0x10 -> counter 11, predicted taken to 0x80.
